// File: rtl/gate_bist_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gate_bist_pkg : shared states and stimulus constants for the gate BIST engine
// Rev 1.0
// ---------------------------------------------------------------------------
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'h0805;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] B_MASK    = 16'h0818;
    localparam logic [15:0] NO_FAIL   = 16'hFFFF;

    // Operand B is a byte-swapped, masked copy of operand A.
    function automatic logic [15:0] operand_b(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ B_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_bist_lfsr16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lfsr16 : one combinational Galois step (shift right, XOR taps on LSB out)
// Rev 1.0
// ---------------------------------------------------------------------------
module lfsr16
    import gate_bist_pkg::*;
(
    input  logic [15:0] i_state,
    output logic [15:0] o_next
);

    assign o_next = {1'b0, i_state[15:1]} ^ (i_state[0] ? LFSR_TAPS : 16'h0000);

endmodule
`default_nettype wire

// File: rtl/gate_bist.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gate_bist : self-checking stimulus/compare engine for 16-bit AND gates.
// Optional GATE_BIST_STOP_ON_FAIL_EN: halt on first mismatch, keep operands.
// Rev 1.0
// ---------------------------------------------------------------------------
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int NUM_VECTORS   = 256,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_fail_idx
);

    localparam int              c_SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(SETTLE_CYCLES - 1);
    localparam logic [c_SW-1:0] c_SETTLE_ONE  = c_SW'(1);
    localparam logic [15:0]     c_LAST_IDX    = 16'(NUM_VECTORS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_a;
    logic [15:0]     r_idx;
    logic [15:0]     r_err;
    logic [15:0]     r_ffi;
    logic [c_SW-1:0] r_settle;

    logic [15:0]     w_a_step;
    logic [15:0]     w_b;
    logic [15:0]     w_expected;
    logic            w_mismatch;
    logic            w_settle_done;
    logic            w_load;
    logic            w_step;

    lfsr16 u_lfsr (
        .i_state (r_a),
        .o_next  (w_a_step)
    );

    assign w_b           = operand_b(r_a);
    assign w_expected    = r_a & w_b;
    assign w_mismatch    = (dut_out != w_expected);
    assign w_settle_done = (r_settle == c_SETTLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt = DRIVE;
                    w_load      = 1'b1;
                end
            end
            DRIVE: begin
                if (w_settle_done) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
`ifdef GATE_BIST_STOP_ON_FAIL_EN
                if (w_mismatch || (r_idx == c_LAST_IDX)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = DRIVE;
                    w_step      = 1'b1;
                end
`else
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = DRIVE;
                    w_step      = 1'b1;
                end
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operands only move on a load or a step, so they are stable across DRIVE and CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= LFSR_SEED;
            r_idx    <= 16'd0;
            r_err    <= 16'd0;
            r_ffi    <= NO_FAIL;
            r_settle <= '0;
        end else if (w_load) begin
            r_a      <= LFSR_SEED;
            r_idx    <= 16'd0;
            r_err    <= 16'd0;
            r_ffi    <= NO_FAIL;
            r_settle <= '0;
        end else begin
            if (r_state == DRIVE) begin
                r_settle <= w_settle_done ? '0 : (r_settle + c_SETTLE_ONE);
            end
            if ((r_state == CHECK) && w_mismatch) begin
                if (r_err != 16'hFFFF) begin
                    r_err <= r_err + 16'd1;
                end
                if (r_ffi == NO_FAIL) begin
                    r_ffi <= r_idx;
                end
            end
            if (w_step) begin
                r_a   <= w_a_step;
                r_idx <= r_idx + 16'd1;
            end
        end
    end

    assign dut_a          = r_a;
    assign dut_b          = w_b;
    assign busy           = (r_state == DRIVE) || (r_state == CHECK);
    assign done           = (r_state == DONE);
    assign pass           = (r_state == DONE) && (r_err == 16'd0);
    assign err_count      = r_err;
    assign first_fail_idx = r_ffi;

endmodule
`default_nettype wire

// File: tb/tb_gate_bist.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gate_bist : directed + randomized fault-injection bench for gate_bist
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_gate_bist;

    localparam int N = 256;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dut_a;
    logic [15:0] dut_b;
    logic [15:0] dut_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] first_fail_idx;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          mode      = 0;
    int          fault_gen = 0;
    logic [15:0] ref_a [N];
    logic [15:0] ref_b [N];
    logic [15:0] fault [N];
    logic [15:0] inj_m;

    always #5 clk = ~clk;

    gate_bist #(
        .WIDTH         (16),
        .NUM_VECTORS   (N),
        .SETTLE_CYCLES (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .dut_a          (dut_a),
        .dut_b          (dut_b),
        .dut_out        (dut_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_idx (first_fail_idx)
    );

    // Gate under test model: correct AND, optionally corrupted per vector or stuck high.
    always @(dut_a, dut_b, mode, fault_gen) begin
        inj_m = 16'h0000;
        for (int k = 0; k < N; k++) begin
            if (ref_a[k] == dut_a) inj_m = fault[k];
        end
        dut_out = (mode == 1) ? 16'hFFFF : ((dut_a & dut_b) ^ inj_m);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
        chk({tag, "_done"}, {15'd0, done}, 16'd0);
        chk({tag, "_pass"}, {15'd0, pass}, 16'd0);
        chk({tag, "_a"},    dut_a, 16'h0805);
        chk({tag, "_b"},    dut_b, 16'h0D10);
        chk({tag, "_err"},  err_count, 16'd0);
        chk({tag, "_ffi"},  first_fail_idx, 16'hFFFF);
    endtask

    // One full run; predicted result comes from the vector list and the fault plan.
    task automatic run(input string tag, input int ign_at);
        int          exp_err;
        int          exp_ffi;
        int          end_c;
        logic [15:0] out;
        logic [15:0] exp_a;
        exp_err = 0;
        exp_ffi = 16'hFFFF;
        end_c   = 2 * N;
        for (int k = 0; k < N; k++) begin
            out = (mode == 1) ? 16'hFFFF : ((ref_a[k] & ref_b[k]) ^ fault[k]);
            if (out != (ref_a[k] & ref_b[k])) begin
                exp_err++;
                if (exp_ffi == 16'hFFFF) exp_ffi = k;
            end
        end
        exp_a = ref_a[N-1];
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        if (exp_err > 0) begin
            exp_err = 1;
            end_c   = 2 * (exp_ffi + 1);
            exp_a   = ref_a[exp_ffi];
        end
`endif
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c <= end_c; c++) begin
            @(negedge clk);
            start = (c == ign_at);
            if (c < end_c) begin
                if (busy !== 1'b1 || done !== 1'b0) begin
                    chk({tag, "_busy"}, {14'd0, busy, done}, 16'd2);
                end else begin
                    n_checks++;
                end
                if (c % 2 == 0) begin
                    chk({tag, "_vec_a"}, dut_a, ref_a[c/2]);
                    chk({tag, "_vec_b"}, dut_b, ref_b[c/2]);
                end
            end else begin
                chk({tag, "_done"}, {15'd0, done}, 16'd1);
                chk({tag, "_idle"}, {15'd0, busy}, 16'd0);
                chk({tag, "_pass"}, {15'd0, pass}, (exp_err == 0) ? 16'd1 : 16'd0);
                chk({tag, "_err"},  err_count, 16'(exp_err));
                chk({tag, "_ffi"},  first_fail_idx, 16'(exp_ffi));
                chk({tag, "_hold_a"}, dut_a, exp_a);
            end
        end
        start = 1'b0;
    endtask

    task automatic clear_faults();
        for (int k = 0; k < N; k++) fault[k] = 16'h0000;
        fault_gen++;
    endtask

    initial begin
        logic [15:0] a;
        a = 16'h0805;
        for (int k = 0; k < N; k++) begin
            ref_a[k] = a;
            ref_b[k] = {a[7:0], a[15:8]} ^ 16'h0818;
            fault[k] = 16'h0000;
            a = a[0] ? ((a >> 1) ^ 16'hB400) : (a >> 1);
        end
        fault_gen++;

        #1 rst_n = 1'b0;
        #1 chk_reset_values("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_values("idle");

        run("clean", -1);
        run("restart_ignore", 50);

        fault[0] = 16'h0001;
        fault_gen++;
        run("fault_idx0", -1);

        clear_faults();
        mode = 1;
        run("stuck_ones", -1);
        mode = 0;

        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) begin
                fault[k] = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
            end
            fault_gen++;
            run("random_faults", -1);
        end

        clear_faults();
        fault[3] = 16'h8000;
        fault_gen++;
        run("fault_idx3", -1);

        clear_faults();
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (98) @(negedge clk);
        chk("midrun_busy", {15'd0, busy}, 16'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_values("async_reset");
        repeat (2) @(negedge clk);
        chk_reset_values("held_reset");
        rst_n = 1'b1;
        mode  = 0;
        run("after_reset", -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Built-in self-test engine for the 16-bit bitwise gate chips (And16 and siblings).
- Generates a deterministic sequence of operand pairs, drives them into the gate under test, samples its output and compares it against an internally computed golden AND.
- Reports pass/fail, error count and index of the first failing vector.
- Sits beside the gate under test; replaces the manual display-and-inspect flow with a self-checking one.

Parameters:
- WIDTH, 16, operand/result width; the stimulus rules below are defined for 16 only.
- NUM_VECTORS, 256, vectors per run (1..65535).
- SETTLE_CYCLES, 1, cycles operands are held before the output is sampled (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled in IDLE or DONE only, ignored while busy.
- dut_a  output  16  operand A to gate under test.
- dut_b  output  16  operand B to gate under test.
- dut_out  input  16  result from gate under test.
- busy  output  1  high from the cycle after start is accepted until the last CHECK.
- done  output  1  level; high in DONE until the next start or reset.
- pass  output  1  valid when done: 1 iff err_count==0.
- err_count  output  16  mismatching vectors so far; saturates at 16'hFFFF.
- first_fail_idx  output  16  index of first mismatch; 16'hFFFF if none.

Behaviour:
- Reset (async, rst_n low): state=IDLE; dut_a=16'h0805, dut_b=16'h0D10; busy=0, done=0, pass=0, err_count=0, first_fail_idx=16'hFFFF; idx=0, settle counter=0.
- Stimulus for vector k:
  - a_0 = 16'h0805; a_(k+1) = Galois LFSR step of a_k, taps 16'hB400 (shift right; if the shifted-out LSB is 1, XOR with taps).
  - b_k = {a_k[7:0], a_k[15:8]} ^ 16'h0818.
  - Expected result = a_k & b_k.
- FSM:
  - IDLE: on start go to DRIVE; clear counters; idx=0; load vector 0.
  - DRIVE: hold dut_a/dut_b for SETTLE_CYCLES cycles, then go to CHECK.
  - CHECK (1 cycle): compare dut_out with the expected result.
    - On mismatch: err_count++; if first_fail_idx==16'hFFFF, record idx.
    - If idx==NUM_VECTORS-1, go to DONE. Otherwise idx++, step the LFSR, go to DRIVE.
  - DONE: done=1; pass = (err_count==0). On start, go to DRIVE with a full restart (same as from IDLE); done clears that cycle.
- Latency: each vector takes SETTLE_CYCLES+1 cycles. done rises NUM_VECTORS*(SETTLE_CYCLES+1)+1 cycles after the start edge (defaults: 513).
- dut_a/dut_b change only on the DRIVE entry edge and are stable throughout DRIVE and CHECK.
- A start pulse while busy has no effect. Reset mid-run aborts immediately to reset values.
- NUM_VECTORS=1: single DRIVE/CHECK, then DONE.
- The LFSR never reaches zero; the seed is nonzero.

Optional Feature:
- Macro GATE_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatching CHECK goes straight to DONE. err_count=1, pass=0, and dut_a/dut_b keep the failing vector for inspection.
- Undefined: the run always completes all NUM_VECTORS vectors.

Decomposition:
- Package gate_bist_pkg:
  - state enum {IDLE, DRIVE, CHECK, DONE};
  - constants LFSR_SEED=16'h0805, LFSR_TAPS=16'hB400, B_MASK=16'h0818, NO_FAIL=16'hFFFF.
- Sub-module lfsr16: combinational next-state function (one Galois step, taps from the package), instantiated once.

Test Plan:
- Fault-free loop (dut_out = dut_a & dut_b), defaults, start pulse at cycle 0 -> done rises at cycle 513; pass=1, err_count=0, first_fail_idx=16'hFFFF; vector 0 observed as a=16'h0805, b=16'h0D10, expected 16'h0800.
- Single-vector fault: invert dut_out[0] only while idx==0 -> err_count=1, first_fail_idx=0, pass=0.
- Stuck-at-all-ones: dut_out = 16'hFFFF -> err_count=256, first_fail_idx=0, pass=0.
- Reset mid-run: assert rst_n low at cycle 100 for 2 cycles -> all outputs return to reset values asynchronously; a new start completes normally with pass=1.
- Restart and ignore: start pulse at cycle 50 while busy is ignored; start in DONE restarts, done drops for the run, and results are identical to the first run.
- With GATE_BIST_STOP_ON_FAIL_EN defined and the fault injected at idx==3 -> DONE is entered after the vector-3 CHECK; err_count=1, first_fail_idx=3, dut_a holds vector 3.
